sigma_delta_dac_sched: RTL and testbench

Sample scheduler for the `sigma_delta_dac` input.

- Two upstream sample sources share one DAC through a round-robin arbiter.
- Granted samples are buffered in a small FIFO.
- One sample is popped into `dac_input` on every `dac_ready` pulse.
- Start-up priming and underrun are managed by a three-state controller, so the DAC never sees undefined data.

---
 rtl/sigma_delta_pkg.sv | 14 +
 rtl/sigma_delta_fifo.sv | 70 +++++++
 rtl/sigma_delta_dac_sched.sv | 150 +++++++++++++++
 tb/tb_sigma_delta_dac_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sigma_delta_pkg.sv
// rtl/sigma_delta_pkg.sv - state type and midscale helper for the sigma-delta DAC sample scheduler
package sigma_delta_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    UNDERRUN = 2'd2
  } sched_state_t;

  function automatic logic [63:0] midscale(input int unsigned bitlen);
    return 64'd1 << (bitlen - 1);
  endfunction

endpackage

// File: rtl/sigma_delta_fifo.sv
// rtl/sigma_delta_fifo.sv - synchronous sample FIFO with flush and occupancy output
module sigma_delta_fifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign full    = (level_q == FULL_LVL);
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Pointers are AW bits wide, so increments wrap modulo DEPTH for free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level_d = level_q + 1'b1;
        2'b01:   level_d = level_q - 1'b1;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/sigma_delta_dac_sched.sv
// rtl/sigma_delta_dac_sched.sv - two-source round-robin sample scheduler feeding the sigma-delta DAC
// SIGMA_DELTA_SCHED_HOLD_LAST_EN: underrun fill repeats the last popped sample instead of midscale.
module sigma_delta_dac_sched
  import sigma_delta_pkg::*;
#(
  parameter int DAC_BITLEN  = 24,
  parameter int FIFO_DEPTH  = 16,
  parameter int START_LEVEL = 8,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DAC_BITLEN-1:0]         s0_data,
  input  logic                          s0_valid,
  output logic                          s0_ready,
  input  logic [DAC_BITLEN-1:0]         s1_data,
  input  logic                          s1_valid,
  output logic                          s1_ready,
  input  logic                          dac_ready,
  output logic [DAC_BITLEN-1:0]         dac_input,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          running,
  output logic [CNT_WIDTH-1:0]          underrun_cnt
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_BITLEN-1:0] MIDSCALE  = DAC_BITLEN'(midscale(DAC_BITLEN));
  localparam logic [LW-1:0]         START_LVL = LW'(START_LEVEL);

  sched_state_t            state_q, state_d;
  logic                    running_q, running_d;
  logic [DAC_BITLEN-1:0]   dac_input_q, dac_input_d;
  logic [CNT_WIDTH-1:0]    underrun_cnt_q, underrun_cnt_d;
  logic                    last_grant_q, last_grant_d;

  logic                    grant, accept_ok, push, pop, flush;
  logic [DAC_BITLEN-1:0]   push_data, fifo_head, fill;
  logic                    fifo_full, fifo_empty;
  logic [LW-1:0]           level;

  sigma_delta_fifo #(
    .WIDTH (DAC_BITLEN),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    if (s0_valid && s1_valid) grant = ~last_grant_q;
    else if (s1_valid)        grant = 1'b1;
    else                      grant = 1'b0;
  end

  // Full blocks both sources even on a popping cycle, keeping ready off the pop path.
  assign accept_ok    = !fifo_full && enable && !rst;
  assign s0_ready     = accept_ok && !grant;
  assign s1_ready     = accept_ok && grant;
  assign push         = (s0_valid && s0_ready) || (s1_valid && s1_ready);
  assign push_data    = grant ? s1_data : s0_data;
  assign last_grant_d = push ? grant : last_grant_q;

`ifdef SIGMA_DELTA_SCHED_HOLD_LAST_EN
  logic [DAC_BITLEN-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = hold_q;
    if (flush)    hold_d = MIDSCALE;
    else if (pop) hold_d = fifo_head;
  end

  always_ff @(posedge clk) begin
    if (rst) hold_q <= MIDSCALE;
    else     hold_q <= hold_d;
  end

  assign fill = hold_q;
`else
  assign fill = MIDSCALE;
`endif

  always_comb begin
    state_d        = state_q;
    dac_input_d    = dac_input_q;
    underrun_cnt_d = underrun_cnt_q;
    pop            = 1'b0;
    flush          = 1'b0;
    if (!enable) begin
      state_d = IDLE;
      flush   = 1'b1;
      if (dac_ready) dac_input_d = MIDSCALE;
    end else begin
      case (state_q)
        IDLE: begin
          if (dac_ready) dac_input_d = MIDSCALE;
          if (level >= START_LVL) state_d = RUN;
        end
        RUN: begin
          if (dac_ready) begin
            if (!fifo_empty) begin
              pop         = 1'b1;
              dac_input_d = fifo_head;
            end else begin
              dac_input_d = fill;
              state_d     = UNDERRUN;
              if (underrun_cnt_q != '1) underrun_cnt_d = underrun_cnt_q + 1'b1;
            end
          end
        end
        UNDERRUN: begin
          if (dac_ready) dac_input_d = fill;
          if (level >= START_LVL) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      running_q      <= 1'b0;
      dac_input_q    <= MIDSCALE;
      underrun_cnt_q <= '0;
      last_grant_q   <= 1'b1;
    end else begin
      state_q        <= state_d;
      running_q      <= running_d;
      dac_input_q    <= dac_input_d;
      underrun_cnt_q <= underrun_cnt_d;
      last_grant_q   <= last_grant_d;
    end
  end

  assign dac_input    = dac_input_q;
  assign fifo_level   = level;
  assign running      = running_q;
  assign underrun_cnt = underrun_cnt_q;

endmodule

// File: tb/tb_sigma_delta_dac_sched.sv
// tb/tb_sigma_delta_dac_sched.sv - directed scoreboard bench for sigma_delta_dac_sched
module tb_sigma_delta_dac_sched;

  localparam logic [23:0] MID = 24'h800000;

  logic        clk = 1'b0;
  logic        rst, enable, dac_ready;
  logic [23:0] s0_data, s1_data, dac_input;
  logic        s0_valid, s1_valid, s0_ready, s1_ready, running;
  logic [4:0]  fifo_level;
  logic [1:0]  underrun_cnt;

  int          tests = 0;
  int          fails = 0;
  logic [23:0] exp_q [$];
  logic [23:0] last_popped = MID;

  sigma_delta_dac_sched #(
    .DAC_BITLEN  (24),
    .FIFO_DEPTH  (16),
    .START_LEVEL (8),
    .CNT_WIDTH   (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .s0_data      (s0_data),
    .s0_valid     (s0_valid),
    .s0_ready     (s0_ready),
    .s1_data      (s1_data),
    .s1_valid     (s1_valid),
    .s1_ready     (s1_ready),
    .dac_ready    (dac_ready),
    .dac_input    (dac_input),
    .fifo_level   (fifo_level),
    .running      (running),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] fill_exp();
`ifdef SIGMA_DELTA_SCHED_HOLD_LAST_EN
    return last_popped;
`else
    return MID;
`endif
  endfunction

  task automatic push_src(input int src, input logic [23:0] d);
    if (src == 0) begin s0_valid = 1'b1; s0_data = d; end
    else          begin s1_valid = 1'b1; s1_data = d; end
    #1;
    check(src == 0 ? "s0_ready" : "s1_ready", src == 0 ? s0_ready : s1_ready, 1);
    exp_q.push_back(d);
    tick();
    s0_valid = 1'b0;
    s1_valid = 1'b0;
  endtask

  task automatic pulse();
    dac_ready = 1'b1;
    tick();
    dac_ready = 1'b0;
  endtask

  task automatic pop_check(input string tag);
    logic [23:0] e;
    pulse();
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 24'hFFFFFF;
    last_popped = e;
    check(tag, dac_input, e);
    tick();
  endtask

  task automatic underrun_check(input logic [1:0] cnt_exp);
    pulse();
    check("underrun_fill", dac_input, fill_exp());
    check("underrun_cnt", underrun_cnt, cnt_exp);
    check("underrun_running", running, 0);
    tick();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; dac_ready = 1'b0;
    s0_valid = 1'b0; s1_valid = 1'b0; s0_data = '0; s1_data = '0;
    tick(); tick();
    rst = 1'b0;
    check("reset_dac_input", dac_input, MID);
    check("reset_level", fifo_level, 0);
    check("reset_running", running, 0);
    check("reset_cnt", underrun_cnt, 0);

    // Priming: 7 samples leave the DAC at midscale, the 8th starts RUN.
    enable = 1'b1;
    for (int i = 0; i < 7; i++) push_src(0, 24'h100000 + 24'(i));
    pulse(); check("prime_dac_mid", dac_input, MID); tick();
    pulse(); check("prime_dac_mid2", dac_input, MID); tick();
    check("prime_running", running, 0);
    check("prime_level7", fifo_level, 7);
    push_src(0, 24'h100007);
    check("prime_level8", fifo_level, 8);
    tick();
    check("prime_run_entry", running, 1);
    for (int i = 0; i < 8; i++) pop_check("prime_order");
    check("drained_level", fifo_level, 0);

    // Underrun: one count per episode, refill via s1 resumes RUN.
    underrun_check(2'd1);
    underrun_check(2'd1);
    for (int i = 0; i < 8; i++) push_src(1, 24'h200000 + 24'(i));
    tick();
    check("refill_running", running, 1);

    // Simultaneous push and pop at level 5.
    for (int i = 0; i < 3; i++) pop_check("refill_order");
    check("level5", fifo_level, 5);
    s0_valid = 1'b1; s0_data = 24'h2000AA; dac_ready = 1'b1;
    #1;
    check("pushpop_ready", s0_ready, 1);
    exp_q.push_back(s0_data);
    tick();
    s0_valid = 1'b0; dac_ready = 1'b0;
    last_popped = exp_q.pop_front();
    check("pushpop_data", dac_input, last_popped);
    check("pushpop_level", fifo_level, 5);
    tick();
    for (int i = 0; i < 5; i++) pop_check("pushpop_order");
    underrun_check(2'd2);

    // Saturation: three more episodes bring the 2-bit counter to its ceiling.
    for (int e = 0; e < 3; e++) begin
      for (int i = 0; i < 8; i++) push_src(0, 24'h300000 + 24'(e * 16 + i));
      tick();
      check("episode_running", running, 1);
      for (int i = 0; i < 8; i++) pop_check("episode_order");
      underrun_check((e == 0) ? 2'd3 : 2'd3);
    end
    check("cnt_saturated", underrun_cnt, 3);

    // Enable drop with 10 queued samples flushes and idles.
    for (int i = 0; i < 10; i++) push_src(0, 24'h400000 + 24'(i));
    check("level10", fifo_level, 10);
    enable = 1'b0;
    tick();
    exp_q.delete();
    last_popped = MID;
    check("disable_level", fifo_level, 0);
    check("disable_running", running, 0);
    pulse(); check("disable_dac_mid", dac_input, MID); tick();

    // Reset in RUN restores every output.
    enable = 1'b1;
    for (int i = 0; i < 8; i++) push_src(0, 24'h500000 + 24'(i));
    tick();
    check("pre_rst_running", running, 1);
    pop_check("pre_rst_pop");
    rst = 1'b1; s0_valid = 1'b1; s0_data = 24'h5000FF;
    #1;
    check("rst_ready_low", s0_ready, 0);
    tick();
    rst = 1'b0; s0_valid = 1'b0;
    exp_q.delete();
    last_popped = MID;
    check("rst_dac_input", dac_input, MID);
    check("rst_level", fifo_level, 0);
    check("rst_running", running, 0);
    check("rst_cnt", underrun_cnt, 0);

    // Round-robin from reset: s0 first, then alternate until full.
    for (int k = 0; k < 16; k++) begin
      s0_valid = 1'b1; s1_valid = 1'b1;
      s0_data = 24'hA00000 + 24'(k / 2);
      s1_data = 24'hB00000 + 24'(k / 2);
      #1;
      check("rr_s0_ready", s0_ready, (k % 2 == 0));
      check("rr_s1_ready", s1_ready, (k % 2 == 1));
      exp_q.push_back((k % 2 == 0) ? s0_data : s1_data);
      tick();
    end
    check("rr_full_level", fifo_level, 16);
    check("rr_full_s0", s0_ready, 0);
    check("rr_full_s1", s1_ready, 0);
    dac_ready = 1'b1;
    #1;
    check("rr_full_pop_s0", s0_ready, 0);
    check("rr_full_pop_s1", s1_ready, 0);
    tick();
    dac_ready = 1'b0; s0_valid = 1'b0; s1_valid = 1'b0;
    last_popped = exp_q.pop_front();
    check("rr_first_out", dac_input, last_popped);
    check("rr_level15", fifo_level, 15);
    tick();
    for (int i = 0; i < 15; i++) pop_check("rr_order");
    check("rr_drained", fifo_level, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
